// File: rtl/wallace_pkg.sv
// Shared constants, stage-valid type and reduction-depth helpers for wallace_mult_pipe.
// Defining WALLACE_SIGNED_EN adds one Baugh-Wooley correction row to the partial-product matrix.
package wallace_pkg;

  localparam int LATENCY = 3;

`ifdef WALLACE_SIGNED_EN
  localparam int EXTRA_ROWS = 1;
`else
  localparam int EXTRA_ROWS = 0;
`endif

  typedef logic [LATENCY-1:0] stage_valid_t;

  // One Wallace level turns every group of three rows into two; leftovers pass through.
  function automatic int reduce_rows(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_at_level(input int width, input int level);
    int n;
    n = width + EXTRA_ROWS;
    for (int l = 0; l < level; l++) n = reduce_rows(n);
    return n;
  endfunction

  function automatic int reduction_depth(input int width);
    int n;
    int d;
    n = width + EXTRA_ROWS;
    d = 0;
    while (n > 2) begin
      n = reduce_rows(n);
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/csa_row.sv
// N-bit row of 3:2 compressors; the carry vector is returned already aligned to its
// output weight (shifted up one bit), so the top carry out of the row is dropped.
module csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = {(x[N-2:0] & y[N-2:0]) | (x[N-2:0] & z[N-2:0]) | (y[N-2:0] & z[N-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier with valid/ready handshakes on both sides.
// Optional macro WALLACE_SIGNED_EN adds Data_in_Signed and Baugh-Wooley signed products.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     Data_in_A,
  input  logic [WIDTH-1:0]     Data_in_B,
  input  logic                 Data_in_Valid,
  output logic                 Data_in_Ready,
`ifdef WALLACE_SIGNED_EN
  input  logic                 Data_in_Signed,
`endif
  output logic [2*WIDTH-1:0]   Data_out_Product,
  output logic                 Data_out_Valid,
  input  logic                 Data_out_Ready
);

  localparam int PW    = 2 * WIDTH;
  localparam int NROWS = WIDTH + EXTRA_ROWS;
  localparam int DEPTH = reduction_depth(WIDTH);

  stage_valid_t  vld;
  logic          adv1;
  logic          adv2;
  logic          adv3;
  logic          sgn;
  logic [PW-1:0] pp [NROWS];
  logic [PW-1:0] s1_rows [NROWS];
  logic [PW-1:0] lvl [DEPTH+1][NROWS];
  logic [PW-1:0] s2_sum;
  logic [PW-1:0] s2_carry;
  logic [PW-1:0] s3_prod;

  // A stage may take new data when it is empty or its contents move on this cycle.
  assign adv3          = !vld[2] || Data_out_Ready;
  assign adv2          = !vld[1] || adv3;
  assign adv1          = !vld[0] || adv2;
  assign Data_in_Ready = rst_n && adv1;

`ifdef WALLACE_SIGNED_EN
  assign sgn = Data_in_Signed;
`else
  assign sgn = 1'b0;
`endif

  // Signed pairs complement the bits that mix one sign bit with a magnitude bit and add
  // the constant 2^WIDTH + 2^(2*WIDTH-1) in the extra row (Baugh-Wooley).
  always_comb begin
    for (int j = 0; j < NROWS; j++) pp[j] = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        pp[j][i+j] = (Data_in_A[i] & Data_in_B[j]) ^ (sgn && ((i == WIDTH-1) != (j == WIDTH-1)));
      end
    end
`ifdef WALLACE_SIGNED_EN
    pp[NROWS-1][WIDTH] = sgn;
    pp[NROWS-1][PW-1]  = sgn;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      if (adv1) vld[0] <= Data_in_Valid;
      if (adv2) vld[1] <= vld[0];
      if (adv3) vld[2] <= vld[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NROWS; j++) s1_rows[j] <= '0;
      s2_sum   <= '0;
      s2_carry <= '0;
      s3_prod  <= '0;
    end else begin
      if (adv1) begin
        for (int j = 0; j < NROWS; j++) s1_rows[j] <= pp[j];
      end
      if (adv2) begin
        s2_sum   <= lvl[DEPTH][0];
        s2_carry <= lvl[DEPTH][1];
      end
      if (adv3) s3_prod <= s2_sum + s2_carry;
    end
  end

  for (genvar r = 0; r < NROWS; r++) begin : g_l0
    assign lvl[0][r] = s1_rows[r];
  end

  // Row slots above a level's live row count are tied to zero and never read.
  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int RIN  = rows_at_level(WIDTH, l);
    localparam int NG   = RIN / 3;
    localparam int ROUT = reduce_rows(RIN);

    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa_row #(.N(PW)) u_csa (
        .x     (lvl[l][3*g]),
        .y     (lvl[l][3*g+1]),
        .z     (lvl[l][3*g+2]),
        .sum   (lvl[l+1][2*g]),
        .carry (lvl[l+1][2*g+1])
      );
    end
    for (genvar r = 0; r < RIN % 3; r++) begin : g_pass
      assign lvl[l+1][2*NG+r] = lvl[l][3*NG+r];
    end
    for (genvar r = ROUT; r < NROWS; r++) begin : g_zero
      assign lvl[l+1][r] = '0;
    end
  end

  assign Data_out_Valid   = vld[2];
  assign Data_out_Product = vld[2] ? s3_prod : '0;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench for wallace_mult_pipe: random and directed pairs, backpressure, reset,
// plus WIDTH=4/32 corner instances; signed cases appear when WALLACE_SIGNED_EN is defined.
`timescale 1ns/1ps
module tb_wallace_mult_pipe;

  localparam int W  = 8;
  localparam int PW = 2 * W;
`ifdef WALLACE_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_valid;
  logic          in_ready;
  logic          in_signed;
  logic [PW-1:0] product;
  logic          out_valid;
  logic          out_ready;

  logic [3:0]  a4, b4;
  logic        v4, r4, ov4;
  logic [7:0]  p4;
  logic [31:0] a32, b32;
  logic        v32, r32, ov32;
  logic [63:0] p32;

  wallace_mult_pipe #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .Data_in_A(a), .Data_in_B(b),
    .Data_in_Valid(in_valid), .Data_in_Ready(in_ready),
`ifdef WALLACE_SIGNED_EN
    .Data_in_Signed(in_signed),
`endif
    .Data_out_Product(product), .Data_out_Valid(out_valid), .Data_out_Ready(out_ready)
  );

  wallace_mult_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .Data_in_A(a4), .Data_in_B(b4),
    .Data_in_Valid(v4), .Data_in_Ready(r4),
`ifdef WALLACE_SIGNED_EN
    .Data_in_Signed(1'b0),
`endif
    .Data_out_Product(p4), .Data_out_Valid(ov4), .Data_out_Ready(1'b1)
  );

  wallace_mult_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .Data_in_A(a32), .Data_in_B(b32),
    .Data_in_Valid(v32), .Data_in_Ready(r32),
`ifdef WALLACE_SIGNED_EN
    .Data_in_Signed(1'b0),
`endif
    .Data_out_Product(p32), .Data_out_Valid(ov32), .Data_out_Ready(1'b1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: plain integer multiplication, sign-extended operands in signed mode.
  function automatic logic [PW-1:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint px;
    longint py;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'(x);
      py = longint'(y);
    end
    return PW'(px * py);
  endfunction

  typedef struct {
    logic [PW-1:0] prod;
    int            issue;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  bit            check_latency = 1'b0;
  bit            was_stalled = 1'b0;
  logic [PW-1:0] held = '0;
  int            run = 0;
  int            max_run = 0;
  int            n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops on every output transfer, pushes on every input transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      was_stalled = 1'b0;
      run = 0;
    end else begin
      if (was_stalled) begin
        check_output("stall_valid", out_valid, 1);
        check_output("stall_hold", product, held);
      end
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (sb.size() == 0) begin
          check_output("unexpected_output", out_valid, 0);
        end else begin
          check_output("product", product, sb[0].prod);
          if (out_ready) begin
            if (check_latency) check_output("latency", cyc - sb[0].issue, 3);
            void'(sb.pop_front());
            n_out++;
          end
        end
      end else begin
        run = 0;
        check_output("idle_zero", product, 0);
      end
      was_stalled = out_valid && !out_ready;
      held = product;
      if (in_valid && in_ready)
        sb.push_back('{prod: ref_product(a, b, SIGNED_EN && in_signed), issue: cyc});
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the edge that took the pair.
  task automatic apply_stimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    a = x;
    b = y;
    in_signed = s;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      waited++;
      @(posedge clk);
      #1;
    end
    if (!ok) check_output("accept_timeout", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [PW-1:0] expected, input string name);
    int w;
    apply_stimulus(x, y, s, w);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_output({name, "_valid"}, out_valid, 1);
    check_output(name, product, expected);
    @(posedge clk);
    #1;
  endtask

  task automatic corner4(input logic [3:0] x, input logic [3:0] y);
    a4 = x;
    b4 = y;
    v4 = 1'b1;
    @(negedge clk);
    check_output("w4_ready", r4, 1);
    @(posedge clk);
    #1;
    v4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_output("w4_valid", ov4, 1);
    check_output("w4_product", p4, 64'(x) * 64'(y));
    @(posedge clk);
    #1;
  endtask

  task automatic corner32(input logic [31:0] x, input logic [31:0] y);
    a32 = x;
    b32 = y;
    v32 = 1'b1;
    @(negedge clk);
    check_output("w32_ready", r32, 1);
    @(posedge clk);
    #1;
    v32 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_output("w32_valid", ov32, 1);
    check_output("w32_product", p32, 64'(x) * 64'(y));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int w;
    int n_before;
    bit stim_done;

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    a4 = '0; b4 = '0; v4 = 1'b0;
    a32 = '0; b32 = '0; v32 = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_product", product, 0);
    check_output("reset_in_ready", in_ready, 0);
    @(posedge clk);
    #1;

    // First pair is waiting when reset releases and must go in on the very next edge.
    rst_n = 1'b1;
    check_latency = 1'b1;
    apply_stimulus(8'd255, 8'd255, 1'b0, w);
    check_output("first_accept_cycles", w, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_output("fe01_valid", out_valid, 1);
    check_output("fe01_value", product, 16'hFE01);
    @(posedge clk);
    #1;
    idle(3);

    max_run = 0;
    n_before = n_out;
    for (int i = 0; i < 20; i++) apply_stimulus(W'($urandom), W'($urandom), 1'b0, w);
    idle(6);
    check_output("b2b_run", max_run, 20);
    check_output("b2b_count", n_out - n_before, 20);

    // Backpressure: three pairs fill the pipe, the fourth must wait.
    check_latency = 1'b0;
    out_ready = 1'b0;
    n_before = n_out;
    for (int i = 0; i < 3; i++) apply_stimulus(W'($urandom), W'($urandom), 1'b0, w);
    a = 8'd17;
    b = 8'd29;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("full_in_ready", in_ready, 0);
      check_output("full_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    apply_stimulus(8'd17, 8'd29, 1'b0, w);
    idle(6);
    check_output("bp_count", n_out - n_before, 4);
    check_output("bp_drained", sb.size(), 0);

    // Random valid gaps against random downstream stalls.
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          apply_stimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), w);
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(10);
    check_output("random_drained", sb.size(), 0);

    // Reset with two products in flight.
    check_latency = 1'b1;
    apply_stimulus(8'd200, 8'd100, 1'b0, w);
    apply_stimulus(8'd3, 8'd5, 1'b0, w);
    rst_n = 1'b0;
    #1;
    check_output("midreset_out_valid", out_valid, 0);
    check_output("midreset_product", product, 0);
    check_output("midreset_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_before = n_out;
    idle(8);
    check_output("post_reset_outputs", n_out - n_before, 0);

`ifdef WALLACE_SIGNED_EN
    directed(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_min");
    directed(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1_p1");
    directed(8'h80, 8'h80, 1'b0, 16'h4000, "u_80_80");
    directed(8'hFF, 8'h01, 1'b0, 16'h00FF, "u_ff_01");
`endif
    directed(8'd0, 8'd255, 1'b0, 16'h0000, "w8_zero_max");
    directed(8'd1, 8'd255, 1'b0, 16'h00FF, "w8_one_max");

    corner4(4'd0, 4'hF);
    corner4(4'hF, 4'hF);
    corner4(4'd1, 4'hF);
    corner32(32'd0, 32'hFFFF_FFFF);
    corner32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    corner32(32'd1, 32'hFFFF_FFFF);

    idle(4);
    check_output("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
